// File: rtl/array_heap_pkg.sv
// Shared types and default sizing for the array heap engine.
package array_heap_pkg;

  typedef enum logic [2:0] {
    OP_ALLOC  = 3'd0,
    OP_FREE   = 3'd1,
    OP_PUSH   = 3'd2,
    OP_POP    = 3'd3,
    OP_GET    = 3'd4,
    OP_SET    = 3'd5,
    OP_SIZE   = 3'd6,
    OP_INSERT = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 12;
  localparam int DEF_NAREA   = 10;
  localparam int DEF_NARRAYS = 16;

endpackage

// File: rtl/array_heap_free_stack.sv
// LIFO of freed array ids; the most recently freed id is reused first.
module array_heap_free_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 4,
  localparam int PW   = $clog2(DEPTH + 1),
  localparam int XW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ftop;
  logic [PW-1:0] tm1;

  assign empty = (ftop == '0);
  assign full  = (ftop == PW'(DEPTH));
  assign tm1   = ftop - PW'(1);
  assign dout  = mem[tm1[XW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      ftop <= '0;
    end else if (push && !full) begin
      ftop <= ftop + PW'(1);
    end else if (pop && !empty) begin
      ftop <= tm1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !reset) begin
      mem[ftop[XW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/array_heap_unit.sv
// Array heap engine: owns heap RAM, per-array sizes and the free-id stack.
module array_heap_unit
  import array_heap_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NAREA   = DEF_NAREA,
  parameter int NARRAYS = DEF_NARRAYS,
  localparam int AW     = $clog2(NARRAYS),
  localparam int IW     = $clog2(NAREA + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_array,
  input  logic [IW-1:0]    req_index,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic [AW:0]      allocs
);

  localparam int HN  = NARRAYS * NAREA;
  localparam int HAW = $clog2(HN);
  localparam logic [AW:0]   AMAX = (AW+1)'(NARRAYS);
  localparam logic [IW-1:0] SMAX = IW'(NAREA);

  state_t state, nstate;

  logic [WIDTH-1:0] heap [HN];
  logic [IW-1:0]    size [NARRAYS];
  logic [NARRAYS-1:0] live;

  op_t           op;
  logic          acc, err, ok, grow;
  logic [IW-1:0] csize;
  logic          clive;

  logic          fs_empty, fs_full, fs_push, fs_pop;
  logic [AW-1:0] fs_top, aid;

  logic [AW-1:0]    sarr;
  logic [IW-1:0]    sidx, sj;
  logic [WIDTH-1:0] sdata;

  logic [HAW-1:0]   base, sbase, raddr, waddr;
  logic [WIDTH-1:0] rdata, wdata;
  logic             we;

  assign op    = op_t'(req_op);
  assign acc   = req_valid && req_ready;
  assign csize = size[req_array];
  assign clive = live[req_array];
  assign ok    = acc && !err;
  assign grow  = ok && (op == OP_INSERT) && (req_index < csize);
  assign aid   = fs_empty ? allocs[AW-1:0] : fs_top;
  assign base  = HAW'(req_array) * HAW'(NAREA);
  assign sbase = HAW'(sarr) * HAW'(NAREA);

  assign fs_push = ok && (op == OP_FREE);
  assign fs_pop  = ok && (op == OP_ALLOC) && !fs_empty;

  array_heap_free_stack #(
    .DEPTH (NARRAYS),
    .W     (AW)
  ) u_fs (
    .clock (clock),
    .reset (reset),
    .push  (fs_push),
    .pop   (fs_pop),
    .din   (req_array),
    .dout  (fs_top),
    .empty (fs_empty),
    .full  (fs_full)
  );

  always_comb begin
    err = 1'b0;
    case (op)
      OP_ALLOC:  err = fs_empty && (allocs == AMAX);
      OP_FREE:   err = !clive || fs_full;
      OP_PUSH:   err = !clive || (csize == SMAX);
      OP_POP:    err = !clive || (csize == '0);
      OP_GET:    err = !clive || (req_index >= csize);
      OP_SET:    err = !clive || (req_index >= SMAX);
      OP_SIZE:   err = !clive;
      OP_INSERT: err = !clive || (csize == SMAX) || (req_index > csize);
      default:   err = 1'b1;
    endcase
  end

  // One read and one write per cycle; an INSERT moves the top element on acceptance.
  always_comb begin
    raddr = base + HAW'(req_index);
    we    = 1'b0;
    waddr = base + HAW'(csize);
    wdata = req_data;
    if (state == SHIFT) begin
      raddr = sbase + HAW'(sj) - HAW'(1);
      we    = 1'b1;
      waddr = sbase + HAW'(sj);
      wdata = (sj == sidx) ? sdata : rdata;
    end else if (ok) begin
      case (op)
        OP_POP, OP_INSERT: raddr = base + HAW'(csize) - HAW'(1);
        default: ;
      endcase
      case (op)
        OP_PUSH: we = 1'b1;
        OP_SET: begin
          we    = 1'b1;
          waddr = base + HAW'(req_index);
        end
        OP_INSERT: begin
          we = 1'b1;
          if (req_index != csize) wdata = rdata;
        end
        default: ;
      endcase
    end
  end

  assign rdata = heap[raddr];

  always_ff @(posedge clock) begin
    if (we && !reset) heap[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (acc) nstate = grow ? SHIFT : RESP;
      SHIFT: if (sj == sidx) nstate = RESP;
      RESP:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      live      <= '0;
      allocs    <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      sarr      <= '0;
      sidx      <= '0;
      sj        <= '0;
      sdata     <= '0;
      for (int i = 0; i < NARRAYS; i++) size[i] <= '0;
    end else if (state == SHIFT) begin
      if (sj == sidx) size[sarr] <= size[sarr] + IW'(1);
      else            sj <= sj - IW'(1);
    end else if (acc) begin
      rsp_error <= err;
      rsp_data  <= '0;
      if (!err) begin
        case (op)
          OP_ALLOC: begin
            live[aid] <= 1'b1;
            size[aid] <= '0;
            rsp_data  <= WIDTH'(aid);
            if (fs_empty) allocs <= allocs + (AW+1)'(1);
          end
          OP_FREE: begin
            live[req_array] <= 1'b0;
            size[req_array] <= '0;
          end
          OP_PUSH: size[req_array] <= csize + IW'(1);
          OP_POP: begin
            size[req_array] <= csize - IW'(1);
            rsp_data        <= rdata;
          end
          OP_GET: rsp_data <= rdata;
          OP_SET: begin
            if (req_index >= csize) size[req_array] <= req_index + IW'(1);
          end
          OP_SIZE: rsp_data <= WIDTH'(csize);
          OP_INSERT: begin
            if (grow) begin
              sarr  <= req_array;
              sidx  <= req_index;
              sj    <= csize - IW'(1);
              sdata <= req_data;
            end else begin
              size[req_array] <= csize + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_array_heap_unit.sv
// Directed self-checking bench for array_heap_unit.
module tb_array_heap_unit;
  import array_heap_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_array;
  logic [3:0]  req_index;
  logic [11:0] req_data;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic        rsp_error;
  logic [4:0]  allocs;

  int checks = 0;
  int errors = 0;

  logic [11:0] rd;
  logic        re;
  int          lat;
  int          seen;

  always #5 clock = ~clock;

  array_heap_unit #(
    .WIDTH   (12),
    .NAREA   (10),
    .NARRAYS (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_array (req_array),
    .req_index (req_index),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .allocs    (allocs)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] arr,
                       input logic [3:0] idx, input logic [11:0] dat,
                       output logic [11:0] d, output logic e,
                       output int l);
    int n;
    d = '0;
    e = 1'b0;
    l = 0;
    @(negedge clock);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_array = arr;
    req_index = idx;
    req_data  = dat;
    @(posedge clock);
    #1 req_valid = 1'b0;
    do begin
      @(negedge clock);
      l++;
    end while (!rsp_valid && l < 40);
    if (!rsp_valid) chk("rsp_wait", {31'd0, rsp_valid}, 32'd1);
    d = rsp_data;
    e = rsp_error;
  endtask

  task automatic t(input string tag, input logic [2:0] op,
                   input logic [3:0] arr, input logic [3:0] idx,
                   input logic [11:0] dat, input logic [11:0] xd,
                   input logic xe);
    do_op(op, arr, idx, dat, rd, re, lat);
    chk({tag, "_d"}, {20'd0, rd}, {20'd0, xd});
    chk({tag, "_e"}, {31'd0, re}, {31'd0, xe});
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_array = '0;
    req_index = '0;
    req_data  = '0;
    @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ready1", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", {20'd0, rsp_data}, 32'd0);
    chk("rst_err", {31'd0, rsp_error}, 32'd0);
    chk("rst_allocs", {27'd0, allocs}, 32'd0);

    do_op(OP_ALLOC, 0, 0, 0, rd, re, lat);
    chk("alloc0_id", {20'd0, rd}, 32'd0);
    chk("alloc0_lat", lat, 32'd1);
    t("push1", OP_PUSH, 0, 0, 12'd1, 12'd0, 1'b0);
    t("push2", OP_PUSH, 0, 0, 12'd2, 12'd0, 1'b0);
    t("size2", OP_SIZE, 0, 0, 0, 12'd2, 1'b0);
    t("get0", OP_GET, 0, 0, 0, 12'd1, 1'b0);
    t("get1", OP_GET, 0, 1, 0, 12'd2, 1'b0);
    chk("allocs1", {27'd0, allocs}, 32'd1);

    t("alloc1", OP_ALLOC, 0, 0, 0, 12'd1, 1'b0);
    chk("allocs2", {27'd0, allocs}, 32'd2);
    t("free0", OP_FREE, 0, 0, 0, 12'd0, 1'b0);
    t("realloc0", OP_ALLOC, 0, 0, 0, 12'd0, 1'b0);
    chk("allocs_keep", {27'd0, allocs}, 32'd2);
    t("size_new", OP_SIZE, 0, 0, 0, 12'd0, 1'b0);
    t("free1", OP_FREE, 1, 0, 0, 12'd0, 1'b0);
    t("free1_again", OP_FREE, 1, 0, 0, 12'd0, 1'b1);
    t("get_dead", OP_GET, 5, 0, 0, 12'd0, 1'b1);

    t("p10", OP_PUSH, 0, 0, 12'd10, 12'd0, 1'b0);
    t("p20", OP_PUSH, 0, 0, 12'd20, 12'd0, 1'b0);
    t("p30", OP_PUSH, 0, 0, 12'd30, 12'd0, 1'b0);
    do_op(OP_INSERT, 0, 1, 12'd99, rd, re, lat);
    chk("ins_lat", lat, 32'd3);
    chk("ins_err", {31'd0, re}, 32'd0);
    t("g0", OP_GET, 0, 0, 0, 12'd10, 1'b0);
    t("g1", OP_GET, 0, 1, 0, 12'd99, 1'b0);
    t("g2", OP_GET, 0, 2, 0, 12'd20, 1'b0);
    t("g3", OP_GET, 0, 3, 0, 12'd30, 1'b0);
    t("size4", OP_SIZE, 0, 0, 0, 12'd4, 1'b0);
    do_op(OP_INSERT, 0, 4, 12'd40, rd, re, lat);
    chk("app_lat", lat, 32'd1);
    t("g4", OP_GET, 0, 4, 0, 12'd40, 1'b0);
    t("ins_gap", OP_INSERT, 0, 7, 12'd1, 12'd0, 1'b1);

    for (int i = 5; i < 10; i++)
      t("fill", OP_PUSH, 0, 0, 12'(i * 10), 12'd0, 1'b0);
    t("push_full", OP_PUSH, 0, 0, 12'd5, 12'd0, 1'b1);
    t("ins_full", OP_INSERT, 0, 0, 12'd5, 12'd0, 1'b1);
    t("get10", OP_GET, 0, 10, 0, 12'd0, 1'b1);
    t("size10", OP_SIZE, 0, 0, 0, 12'd10, 1'b0);
    t("pop90", OP_POP, 0, 0, 0, 12'd90, 1'b0);
    t("size9", OP_SIZE, 0, 0, 0, 12'd9, 1'b0);

    t("alloc_lifo", OP_ALLOC, 0, 0, 0, 12'd1, 1'b0);
    chk("allocs_lifo", {27'd0, allocs}, 32'd2);
    t("pop_empty", OP_POP, 1, 0, 0, 12'd0, 1'b1);
    t("set5", OP_SET, 1, 5, 12'd7, 12'd0, 1'b0);
    t("size6", OP_SIZE, 1, 0, 0, 12'd6, 1'b0);
    t("get5", OP_GET, 1, 5, 0, 12'd7, 1'b0);
    t("set10", OP_SET, 1, 10, 12'd3, 12'd0, 1'b1);
    t("size6b", OP_SIZE, 1, 0, 0, 12'd6, 1'b0);

    @(negedge clock);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_array = 4'd0;
    req_index = 4'd0;
    req_data  = 12'd55;
    @(posedge clock);
    #1 req_valid = 1'b0;
    seen = 0;
    @(negedge clock);
    if (rsp_valid) seen++;
    @(negedge clock);
    if (rsp_valid) seen++;
    reset = 1'b1;
    @(negedge clock);
    if (rsp_valid) seen++;
    chk("mid_rst_ready0", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready1", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    chk("mid_rst_norsp", seen, 32'd0);
    chk("mid_rst_allocs", {27'd0, allocs}, 32'd0);
    t("post_alloc", OP_ALLOC, 0, 0, 0, 12'd0, 1'b0);
    chk("post_allocs", {27'd0, allocs}, 32'd1);
    t("post_size", OP_SIZE, 0, 0, 0, 12'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_heap_unit.md
# array_heap_unit

Parametrised array heap engine for the zero interpreter's FPGA back end. Owns heap memory, per-array sizes and the freed-array stack. Executes array instructions (alloc, free, push, pop, get, set, size, insert) over a valid/ready request port and a pulsed response port. It replaces per-instruction inline heap code in generated `fpga` modules with one reusable block.

## Interface
- `WIDTH`, 12: heap element and data width in bits.
- `NAREA`, 10: maximum elements per array (area size).
- `NARRAYS`, 16: maximum simultaneously allocated arrays; `AW = $clog2(NARRAYS)`, `IW = $clog2(NAREA+1)`.
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 3: operation code (see package).
- `req_array` in AW: target array id.
- `req_index` in IW: element index (GET/SET/INSERT).
- `req_data` in WIDTH: write data (PUSH/SET/INSERT).
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out WIDTH: result (allocated id, popped/read value, size).
- `rsp_error` out 1: operation rejected; state unchanged.
- `allocs` out AW+1: count of ids ever issued fresh (high-water mark).

## Operation
- Storage: `heap[NARRAYS*NAREA]`, `size[NARRAYS]`, `live[NARRAYS]` bitmap, free stack depth NARRAYS with pointer `ftop`.
- ALLOC (0): if `ftop>0`, pop the id from the free stack; else use `allocs` and increment it. Set size=0, live=1, `rsp_data`=id. Error if `ftop==0 && allocs==NARRAYS`.
- FREE (1): push the id onto the free stack, live=0, size=0. Error if not live.
- PUSH (2): `heap[id*NAREA+size]=data`, size+1. Error if size==NAREA.
- POP (3): size-1, `rsp_data=heap[id*NAREA+size-1]`. Error if size==0.
- GET (4): `rsp_data=heap[id*NAREA+index]`. Error if index>=size.
- SET (5): write the element; if index>=size, size=index+1. Error if index>=NAREA.
- SIZE (6): `rsp_data`=size (zero-extended).
- INSERT (7): shift elements [index..size-1] up by one, one element per cycle starting from the top; then write data at index, size+1. Error if size==NAREA or index>size.
- Any op on a non-live id (except ALLOC) returns an error.
- Error responses: `rsp_data`=0.
- FSM states:
  - IDLE: `req_ready`=1. An accepted op goes to RESP, or to SHIFT for a valid INSERT with index<size.
  - SHIFT: move one element per cycle. After the last move, write data and go to RESP.
  - RESP: pulse `rsp_valid`, return to IDLE.

## Timing
- Acceptance on the edge where `req_valid && req_ready`.
- Non-INSERT ops: `rsp_valid` high in the cycle after acceptance; next acceptance possible one cycle later. Throughput is 1 op per 2 cycles.
- INSERT latency is 1 + (size-index) cycles. An append-equivalent INSERT (index==size) takes 1 cycle.
- No response backpressure: the `rsp_valid` pulse is lost if not sampled.
- Reset:
  - `req_ready`=0 during the reset cycle, then 1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0, `allocs`=0.
  - All size, live and `ftop` cleared. Heap contents are undefined (not cleared).
- Reset mid-SHIFT aborts the operation with no response.
- ALLOC when the free stack is non-empty never increments `allocs`.
- The free stack is LIFO: the most recently freed id is reused first.

## Structure
- `array_heap_pkg`: `op_t` enum (ALLOC..INSERT, 3 bits), `state_t` enum (IDLE, SHIFT, RESP), default parameter constants.
- Sub-module `array_heap_free_stack`: parametrised LIFO of ids with push/pop/empty/full and sync reset.
- The heap is a single inferred RAM with one read and one write port per cycle, which SHIFT respects.

## Test plan
- Reset, ALLOC, PUSH 1, PUSH 2, SIZE, GET 0, GET 1 -> id 0; size 2; data 1 then 2; `allocs`=1.
- ALLOC ×2 (ids 0,1), FREE 0, ALLOC -> id 0 reused, `allocs` stays 2; FREE 1 twice -> second FREE has `rsp_error`=1.
- PUSH 10, 20, 30; INSERT index 1 data 99 -> `rsp_valid` 3 cycles after acceptance; GETs return 10, 99, 20, 30; size 4.
- Fill array to NAREA=10; PUSH -> error; POP on an empty array -> error; GET index 10 -> error; size unchanged.
- SET index 5 data 7 on an empty array -> size 6, GET 5 = 7; SET index 10 -> error.
- Assert reset mid-SHIFT -> no `rsp_valid`, `req_ready`=1 the cycle after, ALLOC returns id 0.
